// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage RV32I pipe: stall/flush enables, E-stage forwarding,
// data-memory wait FSM with sticky timeout. Define HAZARD_PERF_CNT_EN to add stall/flush perf counters.
module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_WIDTH = 5,
  parameter int MEM_TIMEOUT    = 256,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
  input  logic                      resultSrcE_i,
  input  logic                      regWriteM_i,
  input  logic                      regWriteW_i,
  input  logic                      pcSrcE_i,
  input  logic                      memReqM_i,
  input  logic                      memReadyM_i,
  output logic                      stallF_o,
  output logic                      stallD_o,
  output logic                      stallE_o,
  output logic                      stallM_o,
  output logic                      flushD_o,
  output logic                      flushE_o,
  output logic                      flushW_o,
  output logic [1:0]                forwardAE_o,
  output logic [1:0]                forwardBE_o,
  output logic                      memTimeout_o
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0]      stallCycles_o,
  output logic [CNT_WIDTH-1:0]      flushCount_o
`endif
);

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam int                WCNT_W   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_MAX = WCNT_W'(MEM_TIMEOUT);

  logic [0:0]        state_q, state_d;
  logic [WCNT_W-1:0] cnt_q, cnt_d;
  logic              timeout_q, timeout_d;

  logic       lw_stall;
  logic       mem_busy;
  logic [1:0] fwd_a, fwd_b;

  // M-stage result is younger than W, so it wins when both match.
  assign fwd_a = (regWriteM_i && (rdM_i != '0) && (rdM_i == rs1E_i)) ? 2'b10 :
                 (regWriteW_i && (rdW_i != '0) && (rdW_i == rs1E_i)) ? 2'b01 : 2'b00;
  assign fwd_b = (regWriteM_i && (rdM_i != '0) && (rdM_i == rs2E_i)) ? 2'b10 :
                 (regWriteW_i && (rdW_i != '0) && (rdW_i == rs2E_i)) ? 2'b01 : 2'b00;

  assign forwardAE_o = rst ? 2'b00 : fwd_a;
  assign forwardBE_o = rst ? 2'b00 : fwd_b;

  assign lw_stall = resultSrcE_i && (rdE_i != '0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

  // Once waiting, only the ready handshake releases the pipe.
  assign mem_busy = (state_q == ST_MEM_WAIT) ? !memReadyM_i : (memReqM_i && !memReadyM_i);

  always_comb begin
    // NOTE: every output/next-state gets a default first so no path leaves a latch behind.
    stallF_o  = 1'b0;
    stallD_o  = 1'b0;
    stallE_o  = 1'b0;
    stallM_o  = 1'b0;
    flushD_o  = 1'b0;
    flushE_o  = 1'b0;
    flushW_o  = 1'b0;
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;

    if (mem_busy) begin
      stallF_o = 1'b1;
      stallD_o = 1'b1;
      stallE_o = 1'b1;
      stallM_o = 1'b1;
      flushW_o = 1'b1;
      if (state_q == ST_RUN) begin
        state_d = ST_MEM_WAIT;
        cnt_d   = WCNT_W'(1);
      end else begin
        if (cnt_q != WCNT_MAX) cnt_d = cnt_q + WCNT_W'(1);
        if (cnt_d == WCNT_MAX) timeout_d = 1'b1;
      end
    end else begin
      state_d = ST_RUN;
      cnt_d   = '0;
      if (pcSrcE_i) begin
        flushD_o = 1'b1;
        flushE_o = 1'b1;
      end else if (lw_stall) begin
        // The load advances to M next edge, so this bubble naturally lasts one cycle.
        stallF_o = 1'b1;
        stallD_o = 1'b1;
        flushE_o = 1'b1;
      end
    end

    if (rst) begin
      stallF_o = 1'b0;
      stallD_o = 1'b0;
      stallE_o = 1'b0;
      stallM_o = 1'b0;
      flushW_o = 1'b0;
      flushD_o = 1'b1;
      flushE_o = 1'b1;
    end
  end

  // NOTE: reset is synchronous here, so it lives inside the clocked branch, not the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign memTimeout_o = timeout_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_WIDTH-1:0] stall_cycles_q;
  logic [CNT_WIDTH-1:0] flush_count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      flush_count_q  <= '0;
    end else begin
      if (stallF_o) stall_cycles_q <= stall_cycles_q + CNT_WIDTH'(1);
      if (pcSrcE_i && !mem_busy) flush_count_q <= flush_count_q + CNT_WIDTH'(1);
    end
  end

  assign stallCycles_o = stall_cycles_q;
  assign flushCount_o  = flush_count_q;
`endif

endmodule
